// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode seven-segment scanner.
// Scans DIGITS digits from a PAGES-deep hex bus. Page/data/controls are
// snapshotted once per frame so a display never tears. Each slot opens with
// blank cycles to stop ghosting. Leading-zero suppression, decimal points and
// per-digit blink are applied to the snapshot.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PAGES        = 2,
  parameter int SCAN_DIV     = 4096,
  parameter int BLANK_CYC    = 1,
  parameter int BLINK_FRAMES = 32,
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                      CLK_S,
  input  logic                      RST_N,
  input  logic [4*DIGITS*PAGES-1:0] Data,
  input  logic [PW-1:0]             Page,
  input  logic [DIGITS-1:0]         Dp,
  input  logic                      Lz_Sup,
  input  logic [DIGITS-1:0]         Blink_En,
  input  logic                      Enable,
  output logic [DIGITS-1:0]         AN,
  output logic [7:0]                Seg,
  output logic                      Frame_Tick
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int GW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int NW = 4 * DIGITS;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_LIM  = DW'(BLANK_CYC);
  localparam logic [GW-1:0] DIG_LAST   = GW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [DW-1:0]     div_cnt;
  logic [GW-1:0]     dig;
  logic              frame_start;

  logic [NW-1:0]     snap_data;
  logic [DIGITS-1:0] snap_dp;
  logic [DIGITS-1:0] snap_blink;
  logic              snap_lz;

  logic [BW-1:0]     blink_cnt;
  logic              blink_ph;

  logic [NW-1:0]     page_arr [PAGES];
  logic [NW-1:0]     page_sel;

  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] dp_pos;
  logic [DIGITS-1:0] blink_pos;
  logic [DIGITS-1:0] sup_pos;
  logic [DIGITS-1:0] an_sel;

  logic [DIGITS-1:0] an_d;
  logic [7:0]        seg_d;
  logic              lit;

  assign frame_start = (div_cnt == '0) && (dig == '0);

  // Slot prescaler and digit pointer; these run even while the display is dark.
  always_ff @(posedge CLK_S or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      dig     <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig     <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  for (genvar p = 0; p < PAGES; p++) begin : g_page
    assign page_arr[p] = Data[NW*p +: NW];
  end

  // Page mux; an out-of-range page selector falls back to page 0.
  always_comb begin
    page_sel = page_arr[0];
    for (int p = 1; p < PAGES; p++) begin
      if (Page == PW'(p)) page_sel = page_arr[p];
    end
  end

  // Frame snapshot of everything the display shows, taken at the first cycle of slot 0.
  always_ff @(posedge CLK_S or negedge RST_N) begin
    if (!RST_N) begin
      snap_data  <= '0;
      snap_dp    <= '0;
      snap_blink <= '0;
      snap_lz    <= 1'b0;
    end else if (frame_start) begin
      snap_data  <= page_sel;
      snap_dp    <= Dp;
      snap_blink <= Blink_En;
      snap_lz    <= Lz_Sup;
    end
  end

  // Blink phase toggles every BLINK_FRAMES frames.
  always_ff @(posedge CLK_S or negedge RST_N) begin
    if (!RST_N) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Per-scan-position views (position 0 = leftmost digit = MS nibble).
  for (genvar g = 0; g < DIGITS; g++) begin : g_pos
    assign nib[g]               = snap_data[4*(DIGITS-1-g) +: 4];
    assign dp_pos[g]            = snap_dp[DIGITS-1-g];
    assign blink_pos[g]         = snap_blink[DIGITS-1-g];
    assign an_sel[DIGITS-1-g]   = (dig == GW'(g));
    if (g == DIGITS - 1) begin : g_last
      assign sup_pos[g] = 1'b0;
    end else begin : g_lead
      assign sup_pos[g] = snap_lz && (snap_data[NW-1 -: 4*(g+1)] == '0);
    end
  end

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'b0000001;
      4'h1:    f = 7'b1001111;
      4'h2:    f = 7'b0010010;
      4'h3:    f = 7'b0000110;
      4'h4:    f = 7'b1001100;
      4'h5:    f = 7'b0100100;
      4'h6:    f = 7'b0100000;
      4'h7:    f = 7'b0001111;
      4'h8:    f = 7'b0000000;
      4'h9:    f = 7'b0000100;
      4'hA:    f = 7'b0001000;
      4'hB:    f = 7'b1100000;
      4'hC:    f = 7'b0110001;
      4'hD:    f = 7'b1000010;
      4'hE:    f = 7'b0110000;
      default: f = 7'b0111000;
    endcase
    return f;
  endfunction

  // Next anode/segment pattern for the current slot from the snapshot.
  always_comb begin
    lit   = 1'b1;
    seg_d = {hex_font(nib[dig]), ~dp_pos[dig]};
    if (sup_pos[dig]) begin
      if (dp_pos[dig]) begin
        seg_d = 8'hFE;
      end else begin
        seg_d = 8'hFF;
        lit   = 1'b0;
      end
    end
    if (blink_ph && blink_pos[dig]) lit = 1'b0;
    if (div_cnt < BLANK_LIM) lit = 1'b0;
    an_d = lit ? ~an_sel : '1;
    if (!Enable) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end
  end

  // Registered pin drivers so the board sees glitch-free anodes and segments.
  always_ff @(posedge CLK_S or negedge RST_N) begin
    if (!RST_N) begin
      AN         <= '1;
      Seg        <= 8'hFF;
      Frame_Tick <= 1'b0;
    end else begin
      AN         <= an_d;
      Seg        <= seg_d;
      Frame_Tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and randomized bench for seg7_scan_ctrl with
// a cycle-count based reference model.
module tb_seg7_scan_ctrl;

  localparam int DIGITS       = 4;
  localparam int PAGES        = 2;
  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_FRAMES = 2;

  logic        CLK_S = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] Data = '0;
  logic [0:0]  Page = '0;
  logic [3:0]  Dp = '0;
  logic        Lz_Sup = 1'b0;
  logic [3:0]  Blink_En = '0;
  logic        Enable = 1'b0;
  logic [3:0]  AN;
  logic [7:0]  Seg;
  logic        Frame_Tick;

  int tests = 0;
  int failures = 0;
  bit check_en = 1'b0;

  logic [6:0] FONT [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int          k = 0;
  int          nsnap = 0;
  int          obs_div = -1;
  int          obs_dig = -1;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blink = '0;
  logic        m_lz = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [7:0]  exp_seg = 8'hFF;
  logic        exp_tick = 1'b0;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .PAGES(PAGES), .SCAN_DIV(SCAN_DIV),
    .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK_S(CLK_S), .RST_N(RST_N), .Data(Data), .Page(Page), .Dp(Dp),
    .Lz_Sup(Lz_Sup), .Blink_En(Blink_En), .Enable(Enable),
    .AN(AN), .Seg(Seg), .Frame_Tick(Frame_Tick)
  );

  always #5 CLK_S = ~CLK_S;

  // Reference model: slot position is derived from the cycle count since reset.
  always @(posedge CLK_S or negedge RST_N) begin
    int div, dg, pos;
    logic [15:0] sh;
    logic [3:0]  t;
    logic [31:0] dsh;
    logic        dpb, lead, vis;
    logic [7:0]  sg;
    if (!RST_N) begin
      k = 0; nsnap = 0; obs_div = -1; obs_dig = -1;
      m_data = '0; m_dp = '0; m_blink = '0; m_lz = 1'b0;
      exp_an = 4'hF; exp_seg = 8'hFF; exp_tick = 1'b0;
    end else begin
      div = k % SCAN_DIV;
      dg  = (k / SCAN_DIV) % DIGITS;
      pos = DIGITS - 1 - dg;
      exp_tick = (div == 0 && dg == 0);
      if (!Enable) begin
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        sh   = m_data >> (4 * pos);
        t    = m_dp >> pos;
        dpb  = t[0];
        lead = m_lz && (dg != DIGITS - 1) && (sh == 16'h0);
        sg   = {FONT[sh[3:0]], ~dpb};
        vis  = 1'b1;
        if (lead) begin
          if (dpb) sg = 8'hFE;
          else begin sg = 8'hFF; vis = 1'b0; end
        end
        t = m_blink >> pos;
        if (((nsnap / BLINK_FRAMES) % 2 == 1) && t[0]) vis = 1'b0;
        if (div < BLANK_CYC) vis = 1'b0;
        exp_seg = sg;
        exp_an  = vis ? ~(4'b0001 << pos) : 4'hF;
      end
      if (div == 0 && dg == 0) begin
        dsh = (int'(Page) < PAGES) ? (Data >> (16 * int'(Page))) : Data;
        m_data = dsh[15:0];
        m_dp = Dp; m_blink = Blink_En; m_lz = Lz_Sup;
        nsnap++;
      end
      obs_div = div;
      obs_dig = dg;
      k++;
    end
  end

  // Every-cycle comparison of the pins against the model.
  always @(negedge CLK_S) begin
    if (check_en) begin
      tests++;
      if (AN !== exp_an || Seg !== exp_seg || Frame_Tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL model_cmp t=%0t: AN=%b Seg=%h Tick=%b, expected AN=%b Seg=%h Tick=%b",
                 $time, AN, Seg, Frame_Tick, exp_an, exp_seg, exp_tick);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic p, input logic [3:0] dp,
                               input logic lz, input logic [3:0] bl, input logic en);
    Data = d; Page = p; Dp = dp; Lz_Sup = lz; Blink_En = bl; Enable = en;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] an_e, input logic [7:0] seg_e,
                             input logic tick_e, input bit seg_care);
    tests++;
    if (AN !== an_e || (seg_care && Seg !== seg_e) || Frame_Tick !== tick_e) begin
      failures++;
      $display("[TB] FAIL %s: AN=%b Seg=%h Tick=%b, expected AN=%b Seg=%h Tick=%b",
               name, AN, Seg, Frame_Tick, an_e, seg_e, tick_e);
    end
  endtask

  // Advance to the negedge at which the outputs show scan position dg, cycle dv.
  task automatic waitSlot(input int dg, input int dv);
    int n = 0;
    @(negedge CLK_S);
    while (!(obs_dig == dg && obs_div == dv) && n < 100) begin
      @(negedge CLK_S);
      n++;
    end
    if (n >= 100) begin
      tests++;
      failures++;
      $display("[TB] FAIL wait_slot: slot %0d/%0d not reached, last seen %0d/%0d",
               dg, dv, obs_dig, obs_div);
    end
  endtask

  initial begin
    int shown;
    logic [31:0] rd;
    applyStimulus(32'hABCD_1234, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    check_en = 1'b1;
    repeat (3) @(negedge CLK_S);
    checkOutput("reset_state", 4'hF, 8'hFF, 1'b0, 1'b1);
    RST_N = 1'b1;

    // Basic scan of page 0 ("1234").
    @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("first_tick", 4'hF, 8'h00, 1'b1, 1'b0);
    @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("scan_d0", 4'b0111, 8'h9F, 1'b0, 1'b1);
    repeat (4) @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("scan_d1", 4'b1011, 8'h25, 1'b0, 1'b1);
    repeat (4) @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("scan_d2", 4'b1101, 8'h0D, 1'b0, 1'b1);
    repeat (4) @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("scan_d3", 4'b1110, 8'h99, 1'b0, 1'b1);
    repeat (3) @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("tick_period", 4'hF, 8'h00, 1'b1, 1'b0);

    // Page change mid-frame is deferred to the next frame.
    waitSlot(1, 3);
    applyStimulus(32'hABCD_1234, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
    waitSlot(2, 1); checkOutput("pg_old_d2", 4'b1101, 8'h0D, 1'b0, 1'b1);
    waitSlot(3, 1); checkOutput("pg_old_d3", 4'b1110, 8'h99, 1'b0, 1'b1);
    waitSlot(0, 1); checkOutput("pg_new_d0", 4'b0111, 8'h11, 1'b0, 1'b1);
    waitSlot(1, 1); checkOutput("pg_new_d1", 4'b1011, 8'hC1, 1'b0, 1'b1);
    waitSlot(2, 1); checkOutput("pg_new_d2", 4'b1101, 8'h63, 1'b0, 1'b1);
    waitSlot(3, 1); checkOutput("pg_new_d3", 4'b1110, 8'h85, 1'b0, 1'b1);

    // Leading-zero suppression.
    applyStimulus(32'hABCD_0070, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1);
    waitSlot(0, 0);
    waitSlot(0, 1); checkOutput("lz_d0", 4'hF, 8'hFF, 1'b0, 1'b1);
    waitSlot(1, 1); checkOutput("lz_d1", 4'hF, 8'hFF, 1'b0, 1'b1);
    waitSlot(2, 1); checkOutput("lz_d2", 4'b1101, 8'h1F, 1'b0, 1'b1);
    waitSlot(3, 1); checkOutput("lz_d3", 4'b1110, 8'h03, 1'b0, 1'b1);
    applyStimulus(32'hABCD_0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1);
    waitSlot(0, 0);
    waitSlot(2, 1); checkOutput("lz0_d2", 4'hF, 8'hFF, 1'b0, 1'b1);
    waitSlot(3, 1); checkOutput("lz0_d3", 4'b1110, 8'h03, 1'b0, 1'b1);
    applyStimulus(32'hABCD_0070, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b1);
    waitSlot(0, 0);
    waitSlot(0, 1); checkOutput("lz_dp_d0", 4'b0111, 8'hFE, 1'b0, 1'b1);

    // Blink on the rightmost digit: two frames on, two frames off.
    applyStimulus(32'hABCD_1234, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1);
    waitSlot(0, 0);
    shown = 0;
    for (int f = 0; f < 4; f++) begin
      waitSlot(0, 1); checkOutput("blink_steady_d0", 4'b0111, 8'h9F, 1'b0, 1'b1);
      waitSlot(3, 1);
      if (AN == 4'b1110) shown++;
    end
    tests++;
    if (shown != 2) begin
      failures++;
      $display("[TB] FAIL blink_duty: shown in %0d of 4 frames, expected 2", shown);
    end

    // Enable low darkens the display from the next cycle.
    waitSlot(1, 2);
    applyStimulus(32'hABCD_1234, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
    @(negedge CLK_S); checkOutput("enable_off", 4'hF, 8'hFF, 1'b0, 1'b1);
    applyStimulus(32'hABCD_1234, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);

    // Asynchronous reset mid-slot, then restart at the leftmost digit.
    waitSlot(2, 2);
    #2 RST_N = 1'b0;
    #1 checkOutput("async_reset", 4'hF, 8'hFF, 1'b0, 1'b1);
    @(negedge CLK_S);
    RST_N = 1'b1;
    @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("rst_tick", 4'hF, 8'h00, 1'b1, 1'b0);
    @(posedge CLK_S); @(negedge CLK_S);
    checkOutput("rst_leftmost", 4'b0111, 8'h9F, 1'b0, 1'b1);

    // Randomized traffic checked cycle-by-cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_S);
      if ($urandom_range(0, 11) == 0) begin
        rd = '0;
        for (int n = 0; n < 8; n++)
          rd = {rd[27:0], ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15))};
        applyStimulus(rd, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                      4'($urandom), 1'($urandom_range(0, 7) != 0));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 RST_N = 1'b0;
        @(negedge CLK_S);
        RST_N = 1'b1;
      end
    end

    @(negedge CLK_S);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
